// File: rtl/uart_rx_controller.sv
// 8N1 UART receiver: synchronises the serial line, centre-samples each bit and
// presents the received byte with a one-cycle done strobe or a framing-error strobe.
module uart_rx_controller #(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx_data,
  output logic       o_rx_done,
  output logic [7:0] o_rx_data,
  output logic       o_frame_err
);

  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF > 0) ? HALF - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Synchroniser resets to the idle (high) line level so reset release never fakes a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= i_rx_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          bit_idx_d = '0;
          state_d   = (HALF == 0) ? DATA : START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_rx_done   = done_q;
  assign o_rx_data   = data_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller at CLKS_PER_BIT=1 and 16 (two instances,
// shared clock/reset); expected bytes and latencies are hand-computed constants.
module tb_uart_rx_controller;

  localparam int LAT1  = 2 + 0 + 9 * 1 + 1;   // SYNC + HALF + 9*CPB + 1 for CPB=1
  localparam int LAT16 = 2 + 7 + 9 * 16 + 1;  // same for CPB=16 (HALF=7)

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] rx_line = 2'b11;

  logic       done1, err1, done16, err16;
  logic [7:0] data1, data16;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  int         done_cnt[2]      = '{0, 0};
  int         err_cnt[2]       = '{0, 0};
  int         both_cnt[2]      = '{0, 0};
  int         wide_cnt[2]      = '{0, 0};
  int         last_done_cyc[2] = '{0, 0};
  int         last_err_cyc[2]  = '{0, 0};
  logic [7:0] last_data[2]     = '{8'h00, 8'h00};
  logic [7:0] prev_data[2]     = '{8'h00, 8'h00};
  logic [1:0] done_prev        = 2'b00;
  logic [1:0] err_prev         = 2'b00;

  uart_rx_controller #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .i_rx_data  (rx_line[0]),
    .o_rx_done  (done1),
    .o_rx_data  (data1),
    .o_frame_err(err1)
  );

  uart_rx_controller #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) u_dut16 (
    .clk        (clk),
    .reset      (reset),
    .i_rx_data  (rx_line[1]),
    .o_rx_done  (done16),
    .o_rx_data  (data16),
    .o_frame_err(err16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic       d, e;
      logic [7:0] v;
      d = (k == 0) ? done1 : done16;
      e = (k == 0) ? err1  : err16;
      v = (k == 0) ? data1 : data16;
      if (d) begin
        done_cnt[k]      <= done_cnt[k] + 1;
        prev_data[k]     <= last_data[k];
        last_data[k]     <= v;
        last_done_cyc[k] <= cyc;
        if (done_prev[k]) wide_cnt[k] <= wide_cnt[k] + 1;
      end
      if (e) begin
        err_cnt[k]      <= err_cnt[k] + 1;
        last_err_cyc[k] <= cyc;
        if (err_prev[k]) wide_cnt[k] <= wide_cnt[k] + 1;
      end
      if (d && e) both_cnt[k] <= both_cnt[k] + 1;
      done_prev[k] <= d;
      err_prev[k]  <= e;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input int which, input logic v, input int n);
    rx_line[which] = v;
    idle(n);
  endtask

  task automatic send_frame(input int which, input logic [7:0] b, input logic stop_v,
                            input int stop_n, output int t_start);
    int cpb;
    cpb     = (which == 0) ? 1 : 16;
    t_start = cyc;
    hold(which, 1'b0, cpb);
    for (int i = 0; i < 8; i++) hold(which, b[i], cpb);
    hold(which, stop_v, stop_n);
    rx_line[which] = 1'b1;
  endtask

  initial begin
    int ts, ts2;

    idle(3);
    reset = 1'b1;
    idle(5);

    check("rst_data1", 32'(data1), 32'h00);
    check("rst_done1", 32'(done1), 32'h0);
    check("rst_err1", 32'(err1), 32'h0);
    check("rst_data16", 32'(data16), 32'h00);
    check("rst_done16", 32'(done16), 32'h0);

    // CPB=1: bits 1,0,0,0,1,1,1,0 LSB-first -> 0x71.
    send_frame(0, 8'h71, 1'b1, 1, ts);
    idle(20);
    check("c1_done_cnt", 32'(done_cnt[0]), 32'd1);
    check("c1_data", 32'(data1), 32'h71);
    check("c1_latency", 32'(last_done_cyc[0] - ts), 32'(LAT1));
    check("c1_no_err", 32'(err_cnt[0]), 32'd0);

    // CPB=1 back-to-back 0x01, 0xFE.
    send_frame(0, 8'h01, 1'b1, 1, ts);
    send_frame(0, 8'hFE, 1'b1, 1, ts2);
    idle(20);
    check("c1_b2b_cnt", 32'(done_cnt[0]), 32'd3);
    check("c1_b2b_first", 32'(prev_data[0]), 32'h01);
    check("c1_b2b_second", 32'(last_data[0]), 32'hFE);
    check("c1_b2b_latency", 32'(last_done_cyc[0] - ts2), 32'(LAT1));

    // CPB=16: 0xA5 with exact latency.
    send_frame(1, 8'hA5, 1'b1, 16, ts);
    idle(20);
    check("c16_done_cnt", 32'(done_cnt[1]), 32'd1);
    check("c16_data", 32'(data16), 32'hA5);
    check("c16_latency", 32'(last_done_cyc[1] - ts), 32'(LAT16));

    // Three-cycle low glitch is rejected, then 0x3C received.
    hold(1, 1'b0, 3);
    hold(1, 1'b1, 40);
    check("glitch_no_done", 32'(done_cnt[1]), 32'd1);
    check("glitch_no_err", 32'(err_cnt[1]), 32'd0);
    send_frame(1, 8'h3C, 1'b1, 16, ts);
    idle(20);
    check("post_glitch_cnt", 32'(done_cnt[1]), 32'd2);
    check("post_glitch_data", 32'(data16), 32'h3C);
    check("post_glitch_latency", 32'(last_done_cyc[1] - ts), 32'(LAT16));

    // Framing error: stop low long enough to cover the sample point, then idle.
    send_frame(1, 8'h55, 1'b0, 8, ts);
    idle(40);
    check("ferr_cnt", 32'(err_cnt[1]), 32'd1);
    check("ferr_no_done", 32'(done_cnt[1]), 32'd2);
    check("ferr_data_held", 32'(data16), 32'h3C);
    check("ferr_latency", 32'(last_err_cyc[1] - ts), 32'(LAT16));

    // CPB=16 back-to-back 0x01, 0xFE.
    send_frame(1, 8'h01, 1'b1, 16, ts);
    send_frame(1, 8'hFE, 1'b1, 16, ts2);
    idle(20);
    check("c16_b2b_cnt", 32'(done_cnt[1]), 32'd4);
    check("c16_b2b_first", 32'(prev_data[1]), 32'h01);
    check("c16_b2b_second", 32'(last_data[1]), 32'hFE);
    check("c16_b2b_latency", 32'(last_done_cyc[1] - ts2), 32'(LAT16));

    // Reset in the middle of the DATA phase of a 0xFF frame.
    hold(1, 1'b0, 16);
    hold(1, 1'b1, 40);
    reset = 1'b0;
    #1;
    check("mid_rst_data16", 32'(data16), 32'h00);
    check("mid_rst_data1", 32'(data1), 32'h00);
    check("mid_rst_done16", 32'(done16), 32'h0);
    idle(2);
    reset = 1'b1;
    idle(200);
    check("mid_rst_no_done", 32'(done_cnt[1]), 32'd4);
    check("mid_rst_no_err", 32'(err_cnt[1]), 32'd1);
    send_frame(1, 8'h81, 1'b1, 16, ts);
    idle(20);
    check("post_rst_cnt", 32'(done_cnt[1]), 32'd5);
    check("post_rst_data", 32'(data16), 32'h81);
    check("post_rst_latency", 32'(last_done_cyc[1] - ts), 32'(LAT16));

    check("c1_overlap", 32'(both_cnt[0]), 32'd0);
    check("c16_overlap", 32'(both_cnt[1]), 32'd0);
    check("c1_pulse_width", 32'(wide_cnt[0]), 32'd0);
    check("c16_pulse_width", 32'(wide_cnt[1]), 32'd0);
    check("c1_err_total", 32'(err_cnt[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
